// File: rtl/seg_pkg.sv
// Shared segment patterns, slot phase type and DP helper for the scan display.
package seg_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} slot_phase_e;

  // Highest set bit of a mask; 0 for an empty mask so only digit 0 is protected.
  function automatic int dp_hi_bit(input logic [31:0] mask);
    int hi;
    hi = 0;
    for (int i = 0; i < 32; i++)
      if (mask[i]) hi = i;
    return hi;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-high 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: per-frame snapshot, blank slot between digits,
// leading-zero blanking and fixed decimal points, all outputs registered.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int                    NUM_DIGITS     = 6,
  parameter int                    SCAN_DIV       = 50000,
  parameter logic [NUM_DIGITS-1:0] DP_MASK        = 6'b010100,
  parameter bit                    SEG_ACTIVE_LOW = 1'b1,
  parameter bit                    DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    hold,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int HI_DP = dp_hi_bit(32'(DP_MASK));

  logic [PW-1:0]           prescaler;
  logic                    tick;
  logic [IW-1:0]           index, index_nxt;
  logic [4*NUM_DIGITS-1:0] snapshot;
  slot_phase_e             phase, phase_nxt;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_run;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   dig_n;

  assign tick      = (prescaler == PW'(SCAN_DIV - 1));
  assign index_nxt = (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
  assign nib       = snapshot[4*int'(index) +: 4];

  bcd_to_seg u_dec (.nib(nib), .seg(seg_raw));

  // Scan from the top digit down; a digit is suppressed while everything above it is zero.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (snapshot[4*i +: 4] == 4'h0);
      lz[i]    = (i > HI_DP) && zero_run;
    end
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      BLANK:   phase_nxt = SHOW;
      SHOW:    phase_nxt = tick ? BLANK : SHOW;
      default: phase_nxt = BLANK;
    endcase
  end

  // Index is already advanced during BLANK, so the decode here is for the upcoming slot.
  always_comb begin
    seg_n = SEG_OFF;
    dp_n  = 1'b0;
    dig_n = '0;
    if (phase_nxt == SHOW) begin
      seg_n        = lz[index] ? SEG_OFF : seg_raw;
      dp_n         = !lz[index] && DP_MASK[index];
      dig_n[index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      prescaler <= '0;
      index     <= '0;
      snapshot  <= '0;
      phase     <= BLANK;
      seg_out   <= {7{SEG_ACTIVE_LOW}};
      dp_out    <= SEG_ACTIVE_LOW;
      dig_sel   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      phase     <= phase_nxt;
      if (tick) begin
        index <= index_nxt;
        // Frame boundary: only here may the displayed value change.
        if (index == IW'(NUM_DIGITS - 1) && !hold)
          snapshot <= digits_in;
      end
      seg_out <= seg_n ^ {7{SEG_ACTIVE_LOW}};
      dp_out  <= dp_n ^ SEG_ACTIVE_LOW;
      dig_sel <= dig_n ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized and directed checks of seg_scan_display against a cycle-indexed display model.
module tb_seg_scan_display;

  localparam int            N   = 6;
  localparam int            SD  = 4;
  localparam int            HI  = 4;
  localparam logic [N-1:0]  DPM = 6'b010100;

  logic           clk = 1'b0;
  logic           sys_rst;
  logic [4*N-1:0] digits_in;
  logic           hold;
  logic [6:0]     seg_out;
  logic           dp_out;
  logic [N-1:0]   dig_sel;

  int             n_tests = 0;
  int             n_fail  = 0;
  int             k;
  logic [4*N-1:0] m_snap;
  bit             chk_en = 1'b0;
  bit             cnt_en = 1'b0;
  int             act_cnt [N];
  logic [6:0]     tab [16];

  seg_scan_display #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .DP_MASK(DPM),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .digits_in(digits_in), .hold(hold),
    .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  initial begin
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < N; i++) act_cnt[i] = 0;
  end

  // Model: k = edges since reset release; slot = k/SD, first cycle of each slot dark.
  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      k      <= 0;
      m_snap <= '0;
    end else begin
      k <= k + 1;
      if ((k + 1) % (SD * N) == 0 && !hold) m_snap <= digits_in;
    end
  end

  always @(negedge clk) begin
    automatic int         d  = (k / SD) % N;
    automatic logic [6:0] es = 7'h00;
    automatic logic       ed = 1'b0;
    automatic logic [N-1:0] eg = '0;
    automatic logic       bl = 1'b0;
    if (chk_en && !sys_rst) begin
      if (k % SD != 0) begin
        bl = (d > HI) && ((m_snap >> (4 * d)) == '0);
        es = bl ? 7'h00 : tab[m_snap[4*d +: 4]];
        ed = !bl && DPM[d];
        eg = N'(1) << d;
      end
      n_tests++;
      if ({seg_out, dp_out, dig_sel} !== {~es, ~ed, ~eg}) begin
        n_fail++;
        $display("FAIL model k=%0d: got seg=%h dp=%b dig=%b, expected seg=%h dp=%b dig=%b",
                 k, seg_out, dp_out, dig_sel, ~es, ~ed, ~eg);
      end
      n_tests++;
      if ($countones(~dig_sel) > 1) begin
        n_fail++;
        $display("FAIL onehot k=%0d: got dig_sel=%b, expected at most one active", k, dig_sel);
      end
      if (cnt_en)
        for (int i = 0; i < N; i++) if (!dig_sel[i]) act_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Stops at the second SHOW cycle of digit d's slot.
  task automatic wait_slot(input int d);
    int t;
    bit found;
    t = 0;
    found = 1'b0;
    while (!found && t < 4 * SD * N) begin
      @(negedge clk);
      t++;
      if (k % SD == 2 && (k / SD) % N == d) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_slot %0d: timeout, got no slot, expected one within %0d cycles", d, 4*SD*N);
    end
  endtask

  task automatic load(input logic [4*N-1:0] v);
    digits_in = v;
    wait_slot(5);
    wait_slot(0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_seg", seg_out, 8'h7F);
    chk("rst_dp", dp_out, 8'h01);
    chk("rst_dig", dig_sel, 8'h3F);
    @(negedge clk);
    #2 sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst   = 1'b1;
    hold      = 1'b0;
    digits_in = '0;
    repeat (2) @(negedge clk);
    #2 sys_rst = 1'b0;
    chk_en = 1'b1;

    // After reset: digit 1 sits below the highest DP, so a zero is shown.
    wait_slot(1);
    chk("t1_seg_d1", seg_out, 8'h40);
    chk("t1_dig_d1", dig_sel, 8'h3D);

    load(24'h012345);
    chk("t2_seg_d0", seg_out, 8'h12);
    wait_slot(4);
    chk("t2_seg_d4", seg_out, 8'h79);
    chk("t2_dp_d4", dp_out, 8'h00);
    wait_slot(5);
    chk("t2_seg_d5", seg_out, 8'h7F);
    chk("t2_dig_d5", dig_sel, 8'h1F);

    load(24'h000007);
    chk("t3_seg_d0", seg_out, 8'h78);
    wait_slot(2);
    chk("t3_dp_d2", dp_out, 8'h00);
    wait_slot(3);
    chk("t3_seg_d3", seg_out, 8'h40);
    chk("t3_dp_d3", dp_out, 8'h01);
    wait_slot(5);
    chk("t3_seg_d5", seg_out, 8'h7F);

    load(24'h012345);
    wait_slot(2);
    hold = 1'b1;
    digits_in = 24'h999999;
    for (int f = 0; f < 3; f++) begin
      wait_slot(0);
      chk("t4_hold_d0", seg_out, 8'h12);
    end
    wait_slot(2);
    hold = 1'b0;
    wait_slot(3);
    chk("t4_midframe_d3", seg_out, 8'h24);
    wait_slot(0);
    chk("t4_new_d0", seg_out, 8'h10);

    load(24'h00000A);
    chk("t5_dash_d0", seg_out, 8'h3F);
    load(24'h000000);
    chk("t5_zero_d0", seg_out, 8'h40);
    wait_slot(5);
    chk("t5_blank_d5", seg_out, 8'h7F);

    @(negedge clk);
    #1 cnt_en = 1'b1;
    repeat (10 * SD * N) @(negedge clk);
    #1 cnt_en = 1'b0;
    for (int i = 0; i < N; i++) chk($sformatf("t6_duty_d%0d", i), 8'(act_cnt[i]), 8'd30);

    for (int it = 0; it < 40; it++) begin
      logic [4*N-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
        if ($urandom_range(0, 1) == 1) v[4*j +: 4] = 4'($urandom_range(0, 15));
      digits_in = v;
      hold = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end
    hold = 1'b0;

    do_reset();
    wait_slot(1);
    chk("rr_seg_d1", seg_out, 8'h40);
    repeat (2 * SD * N) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
